// File: rtl/led_arb_pkg.sv
// Shared types and default parameters for the LED arbiter.
package led_arb_pkg;

   localparam int unsigned DEF_WIDTH  = 8;
   localparam int unsigned DEF_TENURE = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_e;

endpackage

// File: rtl/led_arb_tenure_cnt.sv
// Saturating tenure counter: clears on grant entry, counts granted cycles,
// flags when the owner has held the LEDs for MAX cycles.
module tenure_cnt #(
   parameter int unsigned MAX = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic sat
);

   localparam int unsigned   CW  = (MAX > 1) ? $clog2(MAX) : 1;
   localparam logic [CW-1:0] TOP = CW'(MAX - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, then saturating increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != TOP)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register with registered saturation flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sat   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat   <= (cnt_d == TOP);
      end
   end

endmodule

// File: rtl/led_arb.sv
// Two-requester LED arbiter with minimum-tenure preemption and
// round-robin tie breaking.
module led_arb
   import led_arb_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned TENURE = DEF_TENURE
) (
   input  logic             ledarb_clk_i,
   input  logic             ledarb_rst_n_i,
   input  logic             req0_i,
   input  logic [WIDTH-1:0] data0_i,
   output logic             gnt0_o,
   input  logic             req1_i,
   input  logic [WIDTH-1:0] data1_i,
   output logic             gnt1_o,
   output logic [WIDTH-1:0] leds_o,
   output logic             busy_o
);

   state_e           state_q;
   state_e           state_d;
   logic             last_q;
   logic             last_d;
   logic [WIDTH-1:0] leds_d;
   logic             entry_c;
   logic             hold_c;
   logic             sat;

   // Tenure counter: restarted on every new grant, runs while ownership holds.
   tenure_cnt #(
      .MAX (TENURE)
   ) u_tenure_cnt (
      .clk   (ledarb_clk_i),
      .rst_n (ledarb_rst_n_i),
      .clr   (entry_c),
      .en    (hold_c),
      .sat   (sat)
   );

   // Next-state, grant bookkeeping and LED pattern selection.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      leds_d  = leds_o;
      entry_c = 1'b0;
      hold_c  = 1'b0;

      case (state_q)
         IDLE: begin
            if (req0_i && req1_i) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (req0_i) begin
               state_d = GNT0;
            end else if (req1_i) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            leds_d = data0_i;
            if (!req0_i) begin
               state_d = req1_i ? GNT1 : IDLE;
            end else if (req1_i && sat) begin
               state_d = GNT1;
            end
         end
         GNT1: begin
            leds_d = data1_i;
            if (!req1_i) begin
               state_d = req0_i ? GNT0 : IDLE;
            end else if (req0_i && sat) begin
               state_d = GNT0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      entry_c = (state_d != state_q) && (state_d != IDLE);
      hold_c  = (state_q != IDLE) && (state_d == state_q);
      if (entry_c) begin
         last_d = (state_d == GNT1);
      end
   end

   // State register.
   always_ff @(posedge ledarb_clk_i or negedge ledarb_rst_n_i) begin
      if (!ledarb_rst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Registered grants, busy, LED drive and last-winner record.
   always_ff @(posedge ledarb_clk_i or negedge ledarb_rst_n_i) begin
      if (!ledarb_rst_n_i) begin
         gnt0_o <= 1'b0;
         gnt1_o <= 1'b0;
         busy_o <= 1'b0;
         leds_o <= '0;
         last_q <= 1'b1;
      end else begin
         gnt0_o <= (state_d == GNT0);
         gnt1_o <= (state_d == GNT1);
         busy_o <= (state_d != IDLE);
         leds_o <= leds_d;
         last_q <= last_d;
      end
   end

endmodule

// File: tb/tb_led_arb.sv
// Self-checking bench for led_arb at TENURE=4 with a behavioural owner model.
module tb_led_arb;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned TENURE = 4;

   logic             clk;
   logic             rst_n;
   logic             req0;
   logic             req1;
   logic [WIDTH-1:0] data0;
   logic [WIDTH-1:0] data1;
   logic             gnt0;
   logic             gnt1;
   logic [WIDTH-1:0] leds;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   led_arb #(
      .WIDTH  (WIDTH),
      .TENURE (TENURE)
   ) dut (
      .ledarb_clk_i   (clk),
      .ledarb_rst_n_i (rst_n),
      .req0_i         (req0),
      .data0_i        (data0),
      .gnt0_o         (gnt0),
      .req1_i         (req1),
      .data1_i        (data1),
      .gnt1_o         (gnt1),
      .leds_o         (leds),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who owns the LEDs and for how many cycles so far.
   int               m_owner;
   int               m_held;
   bit               m_last;
   logic [WIDTH-1:0] m_leds;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= -1;
         m_held  <= 0;
         m_last  <= 1'b1;
         m_leds  <= '0;
      end else begin
         automatic int               nxt = m_owner;
         automatic logic             r [2];
         automatic logic [WIDTH-1:0] d [2];
         r[0] = req0; r[1] = req1;
         d[0] = data0; d[1] = data1;
         if (m_owner < 0) begin
            if (r[0] && r[1])  nxt = m_last ? 0 : 1;
            else if (r[0])     nxt = 0;
            else if (r[1])     nxt = 1;
         end else begin
            m_leds <= d[m_owner];
            if (!r[m_owner])
               nxt = r[1 - m_owner] ? 1 - m_owner : -1;
            else if (r[1 - m_owner] && (m_held + 1 >= int'(TENURE)))
               nxt = 1 - m_owner;
         end
         if ((nxt != m_owner) && (nxt >= 0)) begin
            m_held <= 0;
            m_last <= (nxt == 1);
         end else begin
            m_held <= m_held + 1;
         end
         m_owner <= nxt;
      end
   end

   // Every-cycle comparison against the model, plus grant exclusivity.
   always @(negedge clk) begin
      check("model_gnt0", 32'(gnt0), 32'(m_owner == 0));
      check("model_gnt1", 32'(gnt1), 32'(m_owner == 1));
      check("model_busy", 32'(busy), 32'(m_owner >= 0));
      check("model_leds", 32'(leds), 32'(m_leds));
      n_checks++;
      assert (!(gnt0 && gnt1)) else begin
         n_errors++;
         $display("FAIL mutex: gnt0=%0b gnt1=%0b expected not both", gnt0, gnt1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      data0 = '0;
      data1 = '0;
      step();
      step();
      check("rst_gnt0", 32'(gnt0), 32'd0);
      check("rst_gnt1", 32'(gnt1), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_leds", 32'(leds), 32'd0);
      rst_n = 1'b1;

      // Single requester: grant after one edge, pattern after two.
      req0 = 1'b1; data0 = 8'hA5;
      step();
      check("a_gnt0_edge1", 32'(gnt0), 32'd1);
      step();
      check("a_leds_edge2", 32'(leds), 32'hA5);
      check("a_busy", 32'(busy), 32'd1);
      req0 = 1'b0;
      step();
      check("a_idle_busy", 32'(busy), 32'd0);

      // Simultaneous requests after reset, then handover with no bubble.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
      step();
      check("b_tie_gnt0", 32'(gnt0), 32'd1);
      step();
      check("b_leds_d0", 32'(leds), 32'h11);
      req0 = 1'b0;
      step();
      check("b_switch_gnt1", 32'(gnt1), 32'd1);
      check("b_switch_busy", 32'(busy), 32'd1);
      check("b_switch_leds", 32'(leds), 32'h11);
      step();
      check("b_leds_d1", 32'(leds), 32'h22);
      data1 = 8'h44;
      step();
      check("b_leds_follow", 32'(leds), 32'h44);
      req1 = 1'b0;
      step();
      check("b_idle_gnt1", 32'(gnt1), 32'd0);
      check("b_idle_busy", 32'(busy), 32'd0);
      check("b_idle_leds", 32'(leds), 32'h44);

      // Preemption after TENURE cycles, then alternation.
      req0 = 1'b1;
      step();
      check("c_gnt0_entry", 32'(gnt0), 32'd1);
      req1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("c_gnt0_hold", 32'(gnt0), 32'd1);
      end
      step();
      check("c_pre_gnt1", 32'(gnt1), 32'd1);
      check("c_pre_gnt0", 32'(gnt0), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("c_gnt1_hold", 32'(gnt1), 32'd1);
      end
      step();
      check("c_back_gnt0", 32'(gnt0), 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      step();

      // Asynchronous reset mid-GNT1.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req1 = 1'b1; data1 = 8'h3C;
      step();
      check("d_gnt1", 32'(gnt1), 32'd1);
      step();
      check("d_leds_3c", 32'(leds), 32'h3C);
      req0 = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("d_async_gnt1", 32'(gnt1), 32'd0);
      check("d_async_leds", 32'(leds), 32'd0);
      check("d_async_busy", 32'(busy), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("d_resume_gnt0", 32'(gnt0), 32'd1);

      // Randomized traffic with sticky requests and rare resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) req0 = ~req0;
         if ($urandom_range(7) == 0) req1 = ~req1;
         data0 = WIDTH'($urandom);
         data1 = WIDTH'($urandom);
         rst_n = ($urandom_range(299) != 0);
         step();
      end
      rst_n = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
